// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : coin_acceptor
// Brief    : Sensor sync/debounce, coin token FIFO and paced token emitter.
// Revision : 1.0
// ============================================================================
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sense_1,
    input  logic                          sense_2,
    input  logic                          busy,
    output logic [1:0]                    coin,
    output logic                          reject,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int c_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_OCC_W-1:0] c_DEPTH    = c_OCC_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        DEB_LOW  = 1'b0,
        DEB_HIGH = 1'b1
    } deb_state_t;

    typedef enum logic [0:0] {
        EM_READY = 1'b0,
        EM_GAP   = 1'b1
    } em_state_t;

    logic [1:0] sense_vec;
    logic [1:0] push_req;

    assign sense_vec = {sense_2, sense_1};

    // Channel index doubles as the one-hot token code: ch0 -> 01, ch1 -> 10.
    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic               sync1_q;
        logic               sync2_q;
        deb_state_t         state_q;
        logic [c_CNT_W-1:0] cnt_q;
        logic               target_lvl;

        assign target_lvl  = (state_q == DEB_LOW);
        assign push_req[g] = (state_q == DEB_LOW) && sync2_q && (cnt_q == c_DEB_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= DEB_LOW;
                cnt_q   <= '0;
            end else begin
                sync1_q <= sense_vec[g];
                sync2_q <= sync1_q;
                if (sync2_q != target_lvl) begin
                    cnt_q <= '0;
                end else if (cnt_q == c_DEB_LAST) begin
                    cnt_q   <= '0;
                    state_q <= (state_q == DEB_LOW) ? DEB_HIGH : DEB_LOW;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    logic [1:0]         mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_OCC_W-1:0] count_q;
    logic [c_OCC_W-1:0] count_d;
    em_state_t          emit_q;
    logic [1:0]         coin_q;
    logic               reject_q;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic single_req;
    logic jam;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == c_DEPTH);
    assign pop        = (emit_q == EM_READY) && !fifo_empty && !busy;
    assign single_req = ^push_req;
    assign jam        = &push_req;
    // A full queue still accepts when the head leaves on the same edge.
    assign push       = single_req && (!fifo_full || pop);
    assign drop       = jam || (single_req && fifo_full && !pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_q   <= EM_READY;
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
        end else begin
            reject_q <= drop;
            case (emit_q)
                EM_READY: begin
                    if (pop) begin
                        coin_q <= mem_q[rd_ptr_q];
                        emit_q <= EM_GAP;
                    end else begin
                        coin_q <= 2'b00;
                    end
                end
                EM_GAP: begin
                    coin_q <= 2'b00;
                    emit_q <= EM_READY;
                end
                default: begin
                    coin_q <= 2'b00;
                    emit_q <= EM_READY;
                end
            endcase
        end
    end

    assign coin       = coin_q;
    assign reject     = reject_q;
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_acceptor
// Brief    : Vector table plus corner-case sequences; tokens checked in order.
// Revision : 1.0
// ============================================================================
module tb_coin_acceptor;
    logic       clk;
    logic       rst_n;
    logic       sense_1;
    logic       sense_2;
    logic       busy;
    logic [1:0] coin;
    logic       reject;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int tok_cnt  = 0;
    int rej_cnt  = 0;
    logic [1:0] sb [$];
    logic [1:0] exp_tok;

    typedef struct {
        int         s1_len;
        int         s2_len;
        logic [1:0] exp_code;
        int         exp_rej;
    } vec_t;
    vec_t vecs [8];

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sense_1    (sense_1),
        .sense_2    (sense_2),
        .busy       (busy),
        .coin       (coin),
        .reject     (reject),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Token monitor: every emitted token must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (reject) rej_cnt++;
            if (coin != 2'b00) begin
                tok_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL token_unexpected coin=%b expected none", coin);
                end else begin
                    exp_tok = sb.pop_front();
                    if (coin !== exp_tok) begin
                        failures++;
                        $display("FAIL token_order coin=%b expected=%b", coin, exp_tok);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int s1_len, input int s2_len, input int low_len);
        int n;
        n = (s1_len > s2_len) ? s1_len : s2_len;
        for (int c = 0; c < n; c++) begin
            sense_1 = (c < s1_len);
            sense_2 = (c < s2_len);
            tick();
        end
        sense_1 = 1'b0;
        sense_2 = 1'b0;
        repeat (low_len) tick();
    endtask

    initial begin
        int t0;
        int r0;

        vecs[0] = '{10, 0,  2'b01, 0};
        vecs[1] = '{0,  10, 2'b10, 0};
        vecs[2] = '{2,  0,  2'b00, 0};
        vecs[3] = '{0,  3,  2'b00, 0};
        vecs[4] = '{4,  0,  2'b01, 0};
        vecs[5] = '{0,  4,  2'b10, 0};
        vecs[6] = '{8,  8,  2'b00, 1};
        vecs[7] = '{30, 0,  2'b01, 0};

        rst_n = 1'b0; sense_1 = 1'b0; sense_2 = 1'b0; busy = 1'b0;
        repeat (3) tick();
        chk("reset_coin", int'(coin), 0);
        chk("reset_reject", int'(reject), 0);
        chk("reset_count", int'(fifo_count), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single Rs.2: exact push and emit latency, one token while held high.
        t0 = tok_cnt;
        sb.push_back(2'b10);
        sense_2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) begin
                chk("rs2_count_at_push", int'(fifo_count), 1);
                chk("rs2_coin_before", int'(coin), 0);
            end
            if (k == 7) begin
                chk("rs2_coin_valid", int'(coin), 2);
                chk("rs2_count_after_pop", int'(fifo_count), 0);
            end
            if (k == 8) chk("rs2_coin_one_cycle", int'(coin), 0);
        end
        sense_2 = 1'b0;
        repeat (16) tick();
        chk("rs2_tokens", tok_cnt - t0, 1);

        for (int i = 0; i < 8; i++) begin
            t0 = tok_cnt;
            r0 = rej_cnt;
            if (vecs[i].exp_code != 2'b00) sb.push_back(vecs[i].exp_code);
            pulse(vecs[i].s1_len, vecs[i].s2_len, 16);
            chk($sformatf("vec%0d_tokens", i), tok_cnt - t0, (vecs[i].exp_code != 2'b00) ? 1 : 0);
            chk($sformatf("vec%0d_reject", i), rej_cnt - r0, vecs[i].exp_rej);
            chk($sformatf("vec%0d_count", i), int'(fifo_count), 0);
            chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
        end

        // Short low gap between two highs must not re-arm the channel.
        t0 = tok_cnt;
        sb.push_back(2'b01);
        pulse(8, 0, 2);
        pulse(8, 0, 16);
        chk("gap_tokens", tok_cnt - t0, 1);

        // Back-to-back with busy: 10, GAP, held by busy, then 01.
        busy = 1'b1;
        pulse(0, 8, 10);
        pulse(8, 0, 10);
        chk("b2b_count", int'(fifo_count), 2);
        sb.push_back(2'b10);
        sb.push_back(2'b01);
        busy = 1'b0;
        tick();
        chk("b2b_first", int'(coin), 2);
        busy = 1'b1;
        tick();
        chk("b2b_gap", int'(coin), 0);
        tick();
        chk("b2b_busy_hold", int'(coin), 0);
        busy = 1'b0;
        tick();
        chk("b2b_second", int'(coin), 1);
        chk("b2b_count_empty", int'(fifo_count), 0);
        repeat (6) tick();
        chk("b2b_sb_empty", sb.size(), 0);

        // Overflow: fifth coin with a full queue and busy is dropped.
        busy = 1'b1;
        r0 = rej_cnt;
        for (int i = 0; i < 4; i++) pulse(6, 0, 10);
        chk("ovf_count_full", int'(fifo_count), 4);
        chk("ovf_no_reject_yet", rej_cnt - r0, 0);
        pulse(6, 0, 10);
        chk("ovf_count_after", int'(fifo_count), 4);
        chk("ovf_reject", rej_cnt - r0, 1);

        // Full queue with a pop on the push edge: push accepted, count holds.
        t0 = tok_cnt;
        r0 = rej_cnt;
        for (int i = 0; i < 4; i++) sb.push_back(2'b01);
        sb.push_back(2'b10);
        sense_2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) busy = 1'b0;
            if (k == 6) begin
                busy = 1'b1;
                chk("fullpop_count", int'(fifo_count), 4);
            end
        end
        sense_2 = 1'b0;
        repeat (10) tick();
        chk("fullpop_no_reject", rej_cnt - r0, 0);
        busy = 1'b0;
        repeat (14) tick();
        chk("drain_tokens", tok_cnt - t0, 5);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_count", int'(fifo_count), 0);

        // Reset mid-debounce with two coins queued.
        busy = 1'b1;
        pulse(6, 0, 10);
        pulse(0, 6, 10);
        chk("rst_pre_count", int'(fifo_count), 2);
        sense_1 = 1'b1;
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_coin", int'(coin), 0);
        chk("rst_async_reject", int'(reject), 0);
        chk("rst_async_count", int'(fifo_count), 0);
        sense_1 = 1'b0;
        repeat (2) tick();
        t0 = tok_cnt;
        r0 = rej_cnt;
        rst_n = 1'b1;
        busy = 1'b0;
        repeat (16) tick();
        chk("rst_post_count", int'(fifo_count), 0);
        chk("rst_post_tokens", tok_cnt - t0, 0);
        chk("rst_post_reject", rej_cnt - r0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
